dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port, word-wide data memory between two requesters: port 0 (core LSU) and port 1 (DMA/debug).
//  Sequences sub-word stores as read-modify-write, since the memory only has a whole-word write enable.
//  Extracts load lanes from the returned word.
//  Sits between the requesters and the memory's clk/WE/A/WD/RD pins; the memory has an async read and writes on posedge clk.
// PARAMETERS
//  DEPTH   64  memory depth in 32-bit words; word index = addr[31:2]; index >= DEPTH is out of range
// PORTS
//  clk        in   1    single clock, all state updates on posedge
//  reset      in   1    synchronous, active-high reset
//  req_valid  in   2    per-port request; held high until that port's ack
//  req_we     in   2    per-port: 1=store, 0=load
//  req_size   in   4    per-port [2i+1:2i]: 00 byte, 01 half, 10 word, 11 illegal
//  req_addr   in   64   per-port [32i+31:32i] byte address
//  req_wdata  in   64   per-port store data, right-aligned (byte in [7:0], half in [15:0])
//  req_ack    out  2    one-cycle completion pulse to the granted port
//  req_err    out  2    one-cycle error pulse, coincident with req_ack
//  req_rdata  out  32   load data, zero-extended lane; valid only in the req_ack cycle
//  mem_we     out  1    to memory WE
//  mem_a      out  32   to memory A (byte address, word-aligned: [1:0]=0)
//  mem_wd     out  32   to memory WD
//  mem_rd     in   32   from memory RD (combinational)
// BEHAVIOUR
//  Reset values: state IDLE; req_ack=0; req_err=0; req_rdata=0; mem_we=0; mem_a=0; mem_wd=0; priority pointer=port 0.
//  FSM states: IDLE, ACCESS, MERGE, DONE.
//  IDLE
//   - Samples req_valid only in this state.
//   - If any port is valid, latches the winner's we/size/addr/wdata and its port id.
//   - If the request is illegal, goes to DONE with err set:
//     misaligned (half with addr[0]=1, or word with addr[1:0]!=0), size=11, or word index >= DEPTH.
//   - Otherwise goes to ACCESS.
//  ACCESS
//   - mem_a = {addr[31:2],2'b00}.
//   - Load: capture (mem_rd >> 8*addr[1:0]) masked to the size, into req_rdata. Go to DONE.
//   - Word store: mem_we=1, mem_wd=wdata. Go to DONE.
//   - Sub-word store: mem_we=0; capture mem_rd merged with the wdata lane(s) at addr[1:0]. Go to MERGE.
//  MERGE: mem_we=1, mem_wd=merged word, same mem_a. Go to DONE.
//  DONE: req_ack[id]=1, and req_err[id]=err. Go to IDLE.
//  mem_we is 1 only in ACCESS (word store) or MERGE. Loads and errors never assert it.
//  Latency (request high at IDLE cycle N):
//   - Ack at N+2 for loads and word stores.
//   - Ack at N+3 for sub-word stores.
//   - Ack at N+1 for errors (ACCESS skipped).
//  A requester may reassert or change its request the cycle after ack. It is resampled in the next IDLE.
//  Simultaneous requests: port 0 wins. The loser waits and is never dropped.
//  Port 0 valid continuously starves port 1. This is accepted without DMEM_ARB_RR_EN.
//  req_valid dropping before ack is a protocol violation; the latched request still completes.
//  reset asserted mid-operation: return to IDLE next edge, mem_we=0 in that cycle.
//   - A pending MERGE write is discarded.
//   - No ack is issued for the aborted request.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined:
//   - Round-robin. The pointer moves to the non-granted port on every grant.
//   - On a tie, the pointer's port wins.
//   - Reset pointer = port 0.
//  DMEM_ARB_RR_EN undefined: fixed priority, port 0 > port 1; no pointer register.
// STRUCTURE
//  Package dmem_arb_pkg:
//   - size codes SZ_BYTE/SZ_HALF/SZ_WORD.
//   - FSM state encoding.
//   - PORT_CORE=0 and PORT_DMA=1.
//  Sub-module dmem_lane_merge (combinational):
//   - (word, wdata, size, offset) -> merged word.
//   - (word, size, offset) -> extracted lane.
//   - Shared by the ACCESS load path and the RMW path.
// TESTING
//  1 P0 word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_we pulse 1 cycle; load ack N+2, rdata=0xDEADBEEF.
//  2 Memory @0x0=0xFACEFACE; P0 byte store 0xAB @0x2 -> ack N+3; word then reads 0xFAABFACE; half load @0x2 -> 0x0000FAAB.
//  3 P0 and P1 request in the same cycle:
//     - Without RR_EN: P0 acked first, then P1.
//     - With RR_EN and back-to-back requests: grants alternate P0,P1,P0.
//  4 Half store @0x3, word load @0x102 (misaligned), and word load @0x100 (index 64 >= DEPTH):
//     - Each gives ack+err at N+1.
//     - mem_we never asserts.
//  5 reset in the MERGE cycle of a byte store -> mem_we=0 that cycle; memory word unchanged; no ack; next request serviced normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   size_e  : request size codes (byte / half / word / illegal)
//   state_e : arbiter FSM state encoding
//   req_t   : a latched request (we, size, byte address, store data)
//   PORT_CORE / PORT_DMA : requester ids
//   size_mask() : right-aligned lane mask for a size code
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_MERGE  = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [31:0] size_mask(input size_e size);
    case (size)
      SZ_BYTE: size_mask = 32'h0000_00ff;
      SZ_HALF: size_mask = 32'h0000_ffff;
      default: size_mask = 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory pins.
//   Requester side (2 ports, port i in slice i):
//     req_valid[2], req_we[2], req_size[4], req_addr[64], req_wdata[64] -> arbiter
//     req_ack[2], req_err[2], req_rdata[32]                              <- arbiter
//   Memory side:
//     mem_we, mem_a[32], mem_wd[32] <- arbiter ; mem_rd[32] -> arbiter
// modport slave  : the arbiter's view
// modport master : the requester/memory environment's view
interface dmem_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [3:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ack;
  logic [1:0]  req_err;
  logic [31:0] req_rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rd,
    output req_ack, req_err, req_rdata, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, mem_rd,
    input  req_ack, req_err, req_rdata, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_lane_merge.sv
// Combinational lane helper for sub-word accesses.
//   word   in  32  word read from memory
//   wdata  in  32  right-aligned store data
//   size   in  2   size code (byte/half/word)
//   offset in  2   byte offset within the word
//   merged out 32  word with the store lane(s) replaced by wdata
//   lane   out 32  zero-extended lane extracted from word
module dmem_lane_merge
  import dmem_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  offset,
  output logic [31:0] merged,
  output logic [31:0] lane
);

  logic [4:0]  shamt;
  logic [31:0] mask;

  always_comb begin
    shamt  = {offset, 3'b000};
    mask   = size_mask(size);
    lane   = (word >> shamt) & mask;
    merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, word-wide data memory.
// Port 0 is the core LSU, port 1 the DMA/debug requester. Sub-word stores
// are done as read-modify-write; loads return a zero-extended lane.
//   clk, reset (synchronous, active-high)
//   bus : dmem_arbiter_if.slave (requester handshake + memory pins)
// Parameter DEPTH: memory depth in 32-bit words (word index = addr[31:2]).
// Optional feature macro DMEM_ARB_RR_EN: round-robin arbitration instead of
// fixed priority (port 0 > port 1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

  state_e      state_q, state_d;
  req_t        req_q, cand;
  logic        id_q;
  logic        err_q;
  logic [31:0] data_q;
  logic        any_valid;
  logic        winner;
  logic        cand_err;
  logic [31:0] merged;
  logic [31:0] lane;

  // ---------------------------------------------------------------------
  // Arbitration and request legality (only meaningful in IDLE)
  // ---------------------------------------------------------------------
`ifdef DMEM_ARB_RR_EN
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PORT_CORE;
    end else if (state_q == ST_IDLE && any_valid) begin
      // Hand priority to the port that did not win this grant.
      ptr_q <= ~winner;
    end
  end
`endif

  always_comb begin
    any_valid = |bus.req_valid;
`ifdef DMEM_ARB_RR_EN
    // A lone requester wins outright; a tie goes to the pointer's port.
    winner = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
`else
    winner = bus.req_valid[0] ? PORT_CORE : PORT_DMA;
`endif
    cand.we    = winner ? bus.req_we[1] : bus.req_we[0];
    cand.size  = size_e'(winner ? bus.req_size[3:2] : bus.req_size[1:0]);
    cand.addr  = winner ? bus.req_addr[63:32] : bus.req_addr[31:0];
    cand.wdata = winner ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
    cand_err   = (cand.size == SZ_ILL)
              || (cand.size == SZ_HALF && cand.addr[0])
              || (cand.size == SZ_WORD && cand.addr[1:0] != 2'b00)
              || (cand.addr[31:2] >= DEPTH_IDX);
  end

  // ---------------------------------------------------------------------
  // Lane extraction / merge on the word currently read from memory
  // ---------------------------------------------------------------------
  dmem_lane_merge u_lane_merge (
    .word   (bus.mem_rd),
    .wdata  (req_q.wdata),
    .size   (req_q.size),
    .offset (req_q.addr[1:0]),
    .merged (merged),
    .lane   (lane)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: datapath registers carry no reset; they are only observed in
  // states that can be reached after being loaded, and every output they
  // feed is forced to zero outside those states.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && any_valid) begin
      req_q <= cand;
      id_q  <= winner;
      err_q <= cand_err;
    end
    // One capture register serves both the load lane and the RMW word.
    if (state_q == ST_ACCESS) begin
      data_q <= req_q.we ? merged : lane;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_valid) state_d = cand_err ? ST_DONE : ST_ACCESS;
      ST_ACCESS: state_d = (req_q.we && req_q.size != SZ_WORD) ? ST_MERGE : ST_DONE;
      ST_MERGE:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // Write enable and ack are masked by reset so an aborted operation
  // neither writes memory (e.g. a pending MERGE) nor acknowledges.
  // ---------------------------------------------------------------------
  always_comb begin
    bus.req_ack   = '0;
    bus.req_err   = '0;
    bus.req_rdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_a     = '0;
    bus.mem_wd    = '0;
    case (state_q)
      ST_ACCESS: begin
        bus.mem_a = {req_q.addr[31:2], 2'b00};
        if (req_q.we && req_q.size == SZ_WORD) begin
          bus.mem_we = !reset;
          bus.mem_wd = req_q.wdata;
        end
      end
      ST_MERGE: begin
        bus.mem_a  = {req_q.addr[31:2], 2'b00};
        bus.mem_we = !reset;
        bus.mem_wd = data_q;
      end
      ST_DONE: begin
        bus.req_ack[id_q] = !reset;
        bus.req_err[id_q] = err_q && !reset;
        if (!req_q.we && !err_q) bus.req_rdata = data_q;
      end
      default: ;
    endcase
  end

endmodule
